// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory port arbiter.
// Contents: FSM state enum, transaction owner enum, counter-width helper.
package mem_arb_pkg;

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  typedef enum logic {OWN_IF, OWN_D} owner_e;

  // Counter must hold MEM_LATENCY-1; one extra value keeps latency 1 at width 1.
  function automatic int unsigned cnt_width(input int unsigned latency);
    return $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant between the fetch and data requesters.
// Ports:
//   if_valid, d_valid   request valids
//   state               arbiter FSM state (grants only in ST_IDLE)
//   last_owner          previous transaction owner (only with ARB_ROUND_ROBIN_EN)
//   if_grant, d_grant   one-hot (or zero) grant
// Macro ARB_ROUND_ROBIN_EN: alternate on conflict; otherwise data has fixed priority.
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic   if_valid,
  input  logic   d_valid,
  input  state_e state,
`ifdef ARB_ROUND_ROBIN_EN
  input  owner_e last_owner,
`endif
  output logic   if_grant,
  output logic   d_grant
);

  // Grant policy; nothing is granted outside IDLE.
  always_comb begin
    if_grant = 1'b0;
    d_grant  = 1'b0;
    if (state == ST_IDLE) begin
      if (if_valid && d_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
        if (last_owner == OWN_D) begin
          if_grant = 1'b1;
        end else begin
          d_grant = 1'b1;
        end
`else
        d_grant = 1'b1;
`endif
      end else begin
        if_grant = if_valid;
        d_grant  = d_valid;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one word-addressed memory port between instruction fetch and data
// load/store. One transaction at a time; mem_* held for MEM_LATENCY cycles,
// then a one-cycle response pulse to the owner.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   if_req_*/if_addr/if_resp_*  fetch requester (read only)
//   d_req_*/d_addr/d_we/d_wdata/d_resp_*  data requester
//   mem_addr/mem_we/mem_wdata/mem_rdata   memory port (combinational read)
// Macro ARB_ROUND_ROBIN_EN: round-robin on conflict instead of data priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_resp_valid,
  output logic [DATA_W-1:0] if_resp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_resp_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = cnt_width(MEM_LATENCY);

  if (MEM_LATENCY < 1) begin : g_bad_latency
    $error("mem_port_arbiter: MEM_LATENCY must be at least 1");
  end

  state_e           state;
  owner_e           owner;
  logic [CNT_W-1:0] cnt;
  logic             we_q;
  logic             if_grant;
  logic             d_grant;
  logic             accept_if;
  logic             accept_d;
  logic             last_beat;

`ifdef ARB_ROUND_ROBIN_EN
  owner_e last_owner;
`endif

  mem_arb_grant u_grant (
    .if_valid   (if_req_valid),
    .d_valid    (d_req_valid),
    .state      (state),
`ifdef ARB_ROUND_ROBIN_EN
    .last_owner (last_owner),
`endif
    .if_grant   (if_grant),
    .d_grant    (d_grant)
  );

  assign if_req_ready = if_grant;
  assign d_req_ready  = d_grant;
  assign accept_if    = if_req_valid && if_grant;
  assign accept_d     = d_req_valid && d_grant;
  assign last_beat    = (state == ST_BUSY) && (cnt == '0);

  // Reset gates the strobe so a store caught by reset never commits.
  assign mem_we = last_beat && (owner == OWN_D) && we_q && !reset;

  // FSM, latency counter, memory-side latches and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      owner         <= OWN_IF;
      cnt           <= '0;
      we_q          <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      if_resp_valid <= 1'b0;
      d_resp_valid  <= 1'b0;
      if_resp_data  <= '0;
      d_resp_data   <= '0;
    end else begin
      if_resp_valid <= 1'b0;
      d_resp_valid  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept_d) begin
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            we_q      <= d_we;
            owner     <= OWN_D;
            cnt       <= CNT_W'(MEM_LATENCY - 1);
            state     <= ST_BUSY;
          end else if (accept_if) begin
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            we_q      <= 1'b0;
            owner     <= OWN_IF;
            cnt       <= CNT_W'(MEM_LATENCY - 1);
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
            if (owner == OWN_D) begin
              d_resp_valid <= 1'b1;
              d_resp_data  <= we_q ? '0 : mem_rdata;
            end else begin
              if_resp_valid <= 1'b1;
              if_resp_data  <= mem_rdata;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Owner of the most recent accept, used to alternate on conflict.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner <= OWN_IF;
    end else if (accept_d) begin
      last_owner <= OWN_D;
    end else if (accept_if) begin
      last_owner <= OWN_IF;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a MEM_LATENCY=2 instance with a
// behavioural memory, plus a MEM_LATENCY=1 instance sharing that memory.
module tb_mem_port_arbiter;

  localparam int unsigned LAT = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic preload = 1'b1;
  always #5 clk = ~clk;

  logic        if_req_valid = 1'b0, if_req_ready, if_resp_valid;
  logic [31:0] if_addr = '0, if_resp_data;
  logic        d_req_valid = 1'b0, d_req_ready, d_we = 1'b0, d_resp_valid;
  logic [31:0] d_addr = '0, d_wdata = '0, d_resp_data;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  logic        l1_if_req_valid = 1'b0, l1_if_req_ready, l1_if_resp_valid;
  logic [31:0] l1_if_addr = '0, l1_if_resp_data;
  logic        l1_d_req_valid = 1'b0, l1_d_req_ready, l1_d_we = 1'b0, l1_d_resp_valid;
  logic [31:0] l1_d_addr = '0, l1_d_wdata = '0, l1_d_resp_data;
  logic [31:0] l1_mem_addr, l1_mem_wdata, l1_mem_rdata;
  logic        l1_mem_we;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
    .d_we(d_we), .d_wdata(d_wdata), .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset(reset),
    .if_req_valid(l1_if_req_valid), .if_req_ready(l1_if_req_ready), .if_addr(l1_if_addr),
    .if_resp_valid(l1_if_resp_valid), .if_resp_data(l1_if_resp_data),
    .d_req_valid(l1_d_req_valid), .d_req_ready(l1_d_req_ready), .d_addr(l1_d_addr),
    .d_we(l1_d_we), .d_wdata(l1_d_wdata), .d_resp_valid(l1_d_resp_valid),
    .d_resp_data(l1_d_resp_data), .mem_addr(l1_mem_addr), .mem_we(l1_mem_we),
    .mem_wdata(l1_mem_wdata), .mem_rdata(l1_mem_rdata)
  );

  // Word memory: combinational read, write on the clock edge.
  logic [31:0] mem [0:255];
  int we_cnt = 0;
  assign mem_rdata    = mem[mem_addr[9:2]];
  assign l1_mem_rdata = mem[l1_mem_addr[9:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA5A5_A5A5;
      mem[4] <= 32'h0010_0093;
    end else if (mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
      we_cnt <= we_cnt + 1;
    end
  end

  typedef struct { bit is_d; int cyc; } acc_t;
  typedef struct { bit is_d; logic [31:0] data; int cyc; } resp_t;
  typedef struct { bit is_d; logic [31:0] data; } exp_t;

  acc_t  acc[$];
  resp_t got[$];
  exp_t  sb[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;

  // Accept log (cycle index = value of cyc during that cycle).
  always @(posedge clk) begin
    if (!reset) begin
      if (if_req_valid && if_req_ready) acc.push_back('{1'b0, cyc});
      if (d_req_valid && d_req_ready) acc.push_back('{1'b1, cyc});
    end
    cyc <= cyc + 1;
  end

  // Response log.
  always @(negedge clk) begin
    if (if_resp_valid) got.push_back('{1'b0, if_resp_data, cyc});
    if (d_resp_valid) got.push_back('{1'b1, d_resp_data, cyc});
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1);
  end

  task automatic nedge();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) nedge();
    reset = 1'b0;
  endtask

  task automatic wait_acc(input int target, input string what);
    int n = 0;
    while (acc.size() < target && n < 50) begin nedge(); n++; end
    checks++;
    if (acc.size() < target) begin
      errors++;
      $display("FAIL %s_accept: accepts %0d, required %0d", what, acc.size(), target);
    end
  endtask

  task automatic wait_got(input int target, input string what);
    int n = 0;
    while (got.size() < target && n < 50) begin nedge(); n++; end
    checks++;
    if (got.size() < target) begin
      errors++;
      $display("FAIL %s_resp: responses %0d, required %0d", what, got.size(), target);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    preload = 1'b1;
    repeat (3) nedge();
    checks++;
    if ({mem_addr, mem_wdata, mem_we, if_resp_valid, d_resp_valid, if_resp_data,
         d_resp_data, if_req_ready, d_req_ready} !== '0) begin
      errors++;
      $display("FAIL reset_main: mem_addr %h wdata %h we %b rv %b/%b rd %h/%h, required all 0",
               mem_addr, mem_wdata, mem_we, if_resp_valid, d_resp_valid, if_resp_data, d_resp_data);
    end
    checks++;
    if ({l1_mem_addr, l1_mem_wdata, l1_mem_we, l1_if_resp_valid, l1_d_resp_valid,
         l1_if_resp_data, l1_d_resp_data, l1_if_req_ready, l1_d_req_ready} !== '0) begin
      errors++;
      $display("FAIL reset_l1: mem_addr %h we %b rv %b/%b, required all 0",
               l1_mem_addr, l1_mem_we, l1_if_resp_valid, l1_d_resp_valid);
    end
    preload = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_fetch();
    int na, ng;
    exp_t e;
    nedge();
    na = acc.size();
    ng = got.size();
    if_addr = 32'h0000_0010;
    if_req_valid = 1'b1;
    sb.push_back('{1'b0, 32'h0010_0093});
    #1;
    checks++;
    if (if_req_ready !== 1'b1 || d_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL fetch_ready: if %b d %b, required 1 0", if_req_ready, d_req_ready);
    end
    wait_acc(na + 1, "fetch");
    if_req_valid = 1'b0;
    checks++;
    if (mem_addr !== 32'h10 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL fetch_mem: addr %h we %b, required 00000010 0", mem_addr, mem_we);
    end
    wait_got(ng + 1, "fetch");
    repeat (2) nedge();
    checks++;
    if (got.size() != ng + 1) begin
      errors++;
      $display("FAIL fetch_pulses: responses %0d, required %0d", got.size(), ng + 1);
    end
    e = sb.pop_front();
    if (got.size() > ng && acc.size() > na) begin
      checks++;
      if (got[ng].is_d !== e.is_d || got[ng].data !== e.data) begin
        errors++;
        $display("FAIL fetch_data: owner %0d data %h, required %0d %h",
                 got[ng].is_d, got[ng].data, e.is_d, e.data);
      end
      checks++;
      if (got[ng].cyc != acc[na].cyc + int'(LAT) + 1) begin
        errors++;
        $display("FAIL fetch_latency: %0d cycles, required %0d",
                 got[ng].cyc - acc[na].cyc, LAT + 1);
      end
    end
  endtask

  task automatic test_store_load();
    int ng, w0;
    exp_t e;
    ng = got.size();
    w0 = we_cnt;
    d_addr = 32'h40; d_we = 1'b1; d_wdata = 32'hDEAD_BEEF; d_req_valid = 1'b1;
    sb.push_back('{1'b1, 32'h0});
    wait_acc(acc.size() + 1, "store");
    d_req_valid = 1'b0;
    wait_got(ng + 1, "store");
    d_we = 1'b0; d_req_valid = 1'b1;
    sb.push_back('{1'b1, 32'hDEAD_BEEF});
    wait_acc(acc.size() + 1, "load");
    d_req_valid = 1'b0;
    wait_got(ng + 2, "load");
    repeat (2) nedge();
    checks++;
    if (we_cnt - w0 != 1) begin
      errors++;
      $display("FAIL store_we_edges: %0d, required 1", we_cnt - w0);
    end
    checks++;
    if (mem[16] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL store_mem: %h, required deadbeef", mem[16]);
    end
    for (int k = 0; k < 2; k++) begin
      e = sb.pop_front();
      if (got.size() > ng + k) begin
        checks++;
        if (got[ng + k].is_d !== e.is_d || got[ng + k].data !== e.data) begin
          errors++;
          $display("FAIL store_load_data%0d: owner %0d data %h, required %0d %h", k,
                   got[ng + k].is_d, got[ng + k].data, e.is_d, e.data);
        end
      end
    end
  endtask

  task automatic test_conflict();
    int na, ng;
    bit e_d;
    exp_t e;
    do_reset();
    na = acc.size();
    ng = got.size();
    if_addr = 32'h10;
    d_addr = 32'h40; d_we = 1'b0;
    if_req_valid = 1'b1;
    d_req_valid = 1'b1;
    wait_acc(na + 4, "conflict");
    if_req_valid = 1'b0;
    d_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      e_d = (i % 2) == 0;
`else
      e_d = 1'b1;
`endif
      sb.push_back('{e_d, e_d ? 32'hDEAD_BEEF : 32'h0010_0093});
      if (acc.size() > na + i) begin
        checks++;
        if (acc[na + i].is_d !== e_d) begin
          errors++;
          $display("FAIL conflict_grant%0d: owner %0d, required %0d", i, acc[na + i].is_d, e_d);
        end
      end
      if (i > 0 && acc.size() > na + i) begin
        checks++;
        if (acc[na + i].cyc - acc[na + i - 1].cyc != int'(LAT) + 1) begin
          errors++;
          $display("FAIL conflict_spacing%0d: %0d, required %0d", i,
                   acc[na + i].cyc - acc[na + i - 1].cyc, LAT + 1);
        end
      end
    end
    wait_got(ng + 4, "conflict");
    for (int k = 0; k < 4; k++) begin
      e = sb.pop_front();
      if (got.size() > ng + k) begin
        checks++;
        if (got[ng + k].is_d !== e.is_d || got[ng + k].data !== e.data) begin
          errors++;
          $display("FAIL conflict_data%0d: owner %0d data %h, required %0d %h", k,
                   got[ng + k].is_d, got[ng + k].data, e.is_d, e.data);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int na, ng;
    exp_t e;
    nedge();
    na = acc.size();
    ng = got.size();
    if_addr = 32'h10;
    if_req_valid = 1'b1;
    sb.push_back('{1'b0, 32'h0010_0093});
    wait_acc(na + 1, "b2b_first");
    if_req_valid = 1'b0;
    d_addr = 32'h40; d_we = 1'b0; d_req_valid = 1'b1;
    sb.push_back('{1'b1, 32'hDEAD_BEEF});
    wait_acc(na + 2, "b2b_second");
    d_req_valid = 1'b0;
    wait_got(ng + 2, "b2b");
    if (acc.size() > na + 1 && got.size() > ng + 1) begin
      checks++;
      if (acc[na + 1].cyc - acc[na].cyc != int'(LAT) + 1) begin
        errors++;
        $display("FAIL b2b_spacing: %0d, required %0d", acc[na + 1].cyc - acc[na].cyc, LAT + 1);
      end
      checks++;
      if (got[ng].cyc != acc[na + 1].cyc) begin
        errors++;
        $display("FAIL b2b_same_cycle: pulse %0d accept %0d, required equal",
                 got[ng].cyc, acc[na + 1].cyc);
      end
    end
    for (int k = 0; k < 2; k++) begin
      e = sb.pop_front();
      if (got.size() > ng + k) begin
        checks++;
        if (got[ng + k].is_d !== e.is_d || got[ng + k].data !== e.data) begin
          errors++;
          $display("FAIL b2b_data%0d: owner %0d data %h, required %0d %h", k,
                   got[ng + k].is_d, got[ng + k].data, e.is_d, e.data);
        end
      end
    end
  endtask

  task automatic test_reset_mid_store();
    int ng, w0;
    nedge();
    ng = got.size();
    w0 = we_cnt;
    d_addr = 32'h80; d_we = 1'b1; d_wdata = 32'h1234_5678; d_req_valid = 1'b1;
    wait_acc(acc.size() + 1, "rst_store");
    d_req_valid = 1'b0;
    d_we = 1'b0;
    nedge();
    reset = 1'b1;
    #1;
    checks++;
    if (mem_we !== 1'b0) begin
      errors++;
      $display("FAIL rst_store_we: %b, required 0", mem_we);
    end
    nedge();
    checks++;
    if ({mem_addr, mem_wdata, mem_we, if_resp_valid, d_resp_valid, if_resp_data,
         d_resp_data, if_req_ready, d_req_ready} !== '0) begin
      errors++;
      $display("FAIL rst_store_outputs: addr %h wdata %h rd %h/%h, required all 0",
               mem_addr, mem_wdata, if_resp_data, d_resp_data);
    end
    reset = 1'b0;
    repeat (4) nedge();
    checks++;
    if (got.size() != ng || we_cnt != w0) begin
      errors++;
      $display("FAIL rst_store_quiet: responses %0d writes %0d, required %0d %0d",
               got.size(), we_cnt, ng, w0);
    end
    checks++;
    if (mem[32] !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL rst_store_mem: %h, required a5a5a5a5", mem[32]);
    end
  endtask

  task automatic test_lat1();
    exp_t e;
    nedge();
    l1_d_addr = 32'h40; l1_d_we = 1'b0; l1_d_req_valid = 1'b1;
    sb.push_back('{1'b1, 32'hDEAD_BEEF});
    #1;
    checks++;
    if (l1_d_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL lat1_accept: ready %b, required 1", l1_d_req_ready);
    end
    nedge();
    l1_if_req_valid = 1'b1;
    #1;
    checks++;
    if (l1_d_req_ready !== 1'b0 || l1_if_req_ready !== 1'b0 || l1_d_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat1_busy: ready %b/%b resp %b, required 0 0 0",
               l1_if_req_ready, l1_d_req_ready, l1_d_resp_valid);
    end
    l1_if_req_valid = 1'b0;
    l1_d_req_valid = 1'b0;
    nedge();
    e = sb.pop_front();
    checks++;
    if (l1_d_resp_valid !== 1'b1 || l1_d_resp_data !== e.data || l1_mem_we !== 1'b0) begin
      errors++;
      $display("FAIL lat1_resp: valid %b data %h we %b, required 1 %h 0",
               l1_d_resp_valid, l1_d_resp_data, l1_mem_we, e.data);
    end
    nedge();
    checks++;
    if (l1_d_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat1_pulse: valid %b, required 0", l1_d_resp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_load();
    test_conflict();
    test_back_to_back();
    test_reset_mid_store();
    test_lat1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
